// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the decode-side
// valid/ready queue head, with redirect/halt control.
interface instr_fetch_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_addr_o;
  logic [31:0]   instr_i;
  logic          halt_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic [31:0]   instr_o;
  logic [31:0]   instr_pc_o;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] count_o;
  logic          fault_o;

  modport master (
    output pc_addr_o,
    input  instr_i,
    input  halt_i,
    input  redirect_i,
    input  redirect_pc_i,
    output instr_o,
    output instr_pc_o,
    output valid_o,
    input  ready_i,
    output count_o,
    output fault_o
  );

  modport slave (
    input  pc_addr_o,
    output instr_i,
    output halt_i,
    output redirect_i,
    output redirect_pc_i,
    input  instr_o,
    input  instr_pc_o,
    input  valid_o,
    output ready_i,
    input  count_o,
    input  fault_o
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetch PC, circular prefetch queue of {pc, instr}, redirect/halt.
// Optional IF_FETCH_CHECK_EN adds a sticky fault on misaligned redirects or out-of-range fetches.
module instr_fetch_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 100
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  instr_fetch_unit_if.master    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef IF_FETCH_CHECK_EN
  typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_HOLD = 2'd1, ST_FAULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_HOLD = 2'd1} state_t;
`endif

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [63:0]   entry_reg [DEPTH];
  logic [63:0]   head;
  logic          valid;
  logic          deq;
  logic          enq_ok;
  logic          enq;

  assign valid  = (count_reg != '0);
  assign deq    = valid & bus.ready_i;
  assign enq_ok = (state_reg == ST_FETCH) & ~bus.halt_i & ~bus.redirect_i &
                  ((count_reg < CW'(DEPTH)) | deq);

`ifdef IF_FETCH_CHECK_EN
  logic fault_reg, fault_next;
  logic range_bad;
  logic redirect_bad;

  assign range_bad    = ({2'b00, fetch_pc_reg[31:2]} >= 32'(MEM_WORDS));
  assign redirect_bad = |bus.redirect_pc_i[1:0];
  assign enq          = enq_ok & ~range_bad;
  assign bus.fault_o  = fault_reg;
`else
  assign enq          = enq_ok;
  assign bus.fault_o  = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
`ifdef IF_FETCH_CHECK_EN
    fault_next    = fault_reg;
`endif
    if (bus.redirect_i) begin
      // Flush wins over everything, including a head handshake in the same cycle.
      state_next    = ST_FETCH;
      fetch_pc_next = bus.redirect_pc_i & ~32'd3;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
`ifdef IF_FETCH_CHECK_EN
      if (redirect_bad) begin
        state_next = ST_FAULT;
        fault_next = 1'b1;
      end else begin
        fault_next = 1'b0;
      end
`endif
    end else begin
      if (enq) begin
        wr_ptr_next   = wr_ptr_reg + PW'(1);
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (deq) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      count_next = count_reg + CW'(enq) - CW'(deq);
      case (state_reg)
        ST_FETCH: begin
          if (bus.halt_i) begin
            state_next = ST_HOLD;
          end
`ifdef IF_FETCH_CHECK_EN
          else if (enq_ok & range_bad) begin
            state_next = ST_FAULT;
            fault_next = 1'b1;
          end
`endif
        end
        ST_HOLD: begin
          if (!bus.halt_i) begin
            state_next = ST_FETCH;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_FETCH;
      fetch_pc_reg <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
`ifdef IF_FETCH_CHECK_EN
      fault_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
`ifdef IF_FETCH_CHECK_EN
      fault_reg    <= fault_next;
`endif
    end
  end

  // Queue storage needs no reset: empty entries are masked on the outputs.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i) begin
        if (enq && (wr_ptr_reg == PW'(gi))) begin
          entry_reg[gi] <= {fetch_pc_reg, bus.instr_i};
        end
      end
    end
  endgenerate

  assign head           = entry_reg[rd_ptr_reg];
  assign bus.pc_addr_o  = fetch_pc_reg;
  assign bus.valid_o    = valid;
  assign bus.count_o    = count_reg;
  assign bus.instr_o    = valid ? head[31:0]  : 32'd0;
  assign bus.instr_pc_o = valid ? head[63:32] : 32'd0;
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the fetch PC and drives the word address into the combinational-read instruction memory.
- Captures each returned instruction word, tagged with its PC, into a small circular prefetch queue.
- Presents queue entries to the decode stage over a valid/ready handshake; supports branch redirect (flush) and fetch halt.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; word aligned.
- MEM_WORDS, 100, instruction memory depth in words; used only by the optional check.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- pc_addr_o  output  32  byte address to instruction memory; equals the fetch_pc register.
- instr_i  input  32  instruction word from memory; valid in the same cycle as pc_addr_o.
- halt_i  input  1  suspend fetching; queue continues to drain.
- redirect_i  input  1  branch/jump taken; flush queue and restart fetch.
- redirect_pc_i  input  32  new fetch target, sampled when redirect_i=1.
- instr_o  output  32  instruction at queue head.
- instr_pc_o  output  32  PC of the instruction at queue head.
- valid_o  output  1  queue head valid.
- ready_i  input  1  decode accepts head this cycle.
- count_o  output  log2(DEPTH)+1  current queue occupancy.
- fault_o  output  1  sticky fetch fault (optional feature; tied 0 when the feature is compiled out).

Behaviour:
- Clocking/reset: all state updates on the rising edge of clk_i. Reset is synchronous, active-high, on rst_i.
- Reset values:
  - fetch_pc=RESET_PC, so pc_addr_o=RESET_PC.
  - count_o=0, valid_o=0.
  - instr_o=0, instr_pc_o=0.
  - fault_o=0.
  - read/write pointers=0.
  - FSM=FETCH.
- Reset mid-operation discards all queue contents and any pending redirect.
- FSM states:
  - FETCH → HOLD when halt_i=1 and redirect_i=0.
  - HOLD → FETCH when halt_i=0.
  - Any state → FETCH on redirect_i=1.
  - FETCH → FAULT per the optional feature.
- deq = valid_o & ready_i.
- enq = (state==FETCH) & !halt_i & !redirect_i & (count<DEPTH | deq).
  - A full queue with a simultaneous dequeue accepts the new entry.
- On enq:
  - Write {fetch_pc, instr_i} at wr_ptr.
  - wr_ptr advances modulo DEPTH.
  - fetch_pc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).
- On deq: rd_ptr advances modulo DEPTH.
- count update: count += enq − deq. Simultaneous enq and deq leave count unchanged.
- Outputs: valid_o = (count!=0). instr_o and instr_pc_o show the entry at rd_ptr and are 0 when the queue is empty.
- Redirect takes priority over halt_i, enq and deq, including a simultaneous ready_i. On redirect_i=1:
  - count←0, pointers←0.
  - fetch_pc←{redirect_pc_i[31:2],2'b00}.
  - No enqueue that cycle.
  - The head presented that cycle is not consumed.
- Latency:
  - Redirect in cycle N: pc_addr_o shows the target in N+1; target instruction has valid_o=1 in N+2.
  - After reset release in cycle 0: first instruction valid in cycle 1.
- HOLD: fetch_pc frozen, no enqueue, dequeue permitted until empty.
- Queue full with ready_i=0: fetch_pc frozen and pc_addr_o stable.

Optional Feature:
- Macro: IF_FETCH_CHECK_EN.
- When defined, enter FAULT and set fault_o=1 (sticky) on either condition:
  - redirect_i=1 with redirect_pc_i[1:0]!=0.
  - An enqueue would occur with fetch_pc/4 ≥ MEM_WORDS.
- FAULT behaviour:
  - No enqueue; queue still drains.
  - Exit only via reset, or via a redirect to an aligned in-range target, which also clears fault_o.
- When not defined:
  - fault_o tied 0.
  - Misaligned targets silently masked to word alignment.
  - No range check; the FAULT state does not exist.

Test Plan:
- Reset, RESET_PC=0, ready_i=1, memory holding word i = 32'h1000_0000+i:
  - cycle 1: instr_o=32'h1000_0000, instr_pc_o=0.
  - each following cycle: PC +4 and data +1, no bubbles.
- ready_i=0 for 10 cycles:
  - count_o saturates at 4, pc_addr_o holds 32'h10.
  - After ready_i=1, entries appear in order with PCs 0,4,8,C, then 10.
- Queue holds 3 entries; redirect_i=1 with redirect_pc_i=32'h40 and ready_i=1 in the same cycle:
  - next cycle: count_o=0, valid_o=0, pc_addr_o=32'h40.
  - cycle after: instr_pc_o=32'h40.
- halt_i=1 with 4 entries queued:
  - Queue drains to valid_o=0 while pc_addr_o stays constant.
  - After halt_i=0, fetch resumes at the held PC.
- Redirect to 32'hFFFF_FFFC with the check macro off: next enqueued PC after FFFF_FFFC is 0.
- With IF_FETCH_CHECK_EN:
  - redirect_pc_i=32'h42 → fault_o=1 next cycle, no enqueues.
  - redirect_pc_i=32'h8 → fault_o=0 and fetch resumes at 8.
  - Fetch reaching 32'h190 (word 100) → fault_o=1.
